fft_out_reorder_buf: RTL
========================

// Module: fft_out_reorder_buf
// PURPOSE
//  Ping-pong output buffer behind the in-place FFT core. Captures one N-point frame delivered
//  LANES complex samples per clock (e.g. outReal0/outImag0, outReal1/outImag1 lanes).
//  Optionally undoes bit-reversed ordering. Replays the frame one complex sample per clock
//  under a valid/ready handshake. Replaces fixed-offset (clkcnt-226 style) output capture
//  with a reusable, backpressure-aware block.
// PARAMETERS
//  N_POINTS  64  frame length; power of 2, >= LANES
//  DATA_W    16  bits per real/imag component (two's complement, passed through untouched)
//  LANES     2   samples per input beat; power of 2 (1, 2 or 4)
//  BITREV    1   1: input sample index is bit-reversed; output is natural order. 0: no reorder.
// PORTS
//  clk        in   1               rising-edge clock
//  nrst       in   1               asynchronous active-low reset
//  in_start   in   1               qualifies first beat of a frame (valid only with in_valid)
//  in_valid   in   1               input beat valid; no in_ready, source never stalls
//  in_re      in   LANES*DATA_W    lane l at bits [l*DATA_W +: DATA_W]
//  in_im      in   LANES*DATA_W    same packing as in_re
//  out_valid  out  1               out_re/out_im/out_last valid
//  out_ready  in   1               sink accepts when out_valid && out_ready at posedge
//  out_re     out  DATA_W          real part of current output sample
//  out_im     out  DATA_W          imaginary part of current output sample
//  out_last   out  1               high with sample N_POINTS-1 of a frame
//  overflow   out  1               one-cycle pulse: a frame start was dropped
//  busy       out  1               any bank not EMPTY
// BEHAVIOUR
//  Reset: out_valid=0, out_re/out_im=0, out_last=0, overflow=0, busy=0.
//    Both banks EMPTY; write/read pointers 0; fill-order FIFO cleared.
//    Reset mid-operation discards all buffered data immediately (asynchronous).
//  Storage: 2 banks x N_POINTS x 2*DATA_W. Per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
//  Input, beat b = 0..N_POINTS/LANES-1, lane l:
//    Sample index k = b*LANES+l.
//    Write address = BITREV ? bitrev(k, log2 N_POINTS) : k.
//  in_valid && in_start:
//    - A bank is EMPTY: it goes FILLING and beat 0 is written. Lower bank index wins if both are EMPTY.
//    - A bank is already FILLING (restart mid-frame): stay in the same bank; beat counter -> 0;
//      beat 0 is written; earlier partial data is overwritten.
//    - Otherwise: frame dropped, overflow=1 for 1 cycle, remaining beats of that frame ignored.
//  in_valid without in_start is ignored unless a bank is FILLING.
//  Last beat written: bank -> FULL at the same edge; bank index pushed to the 2-entry fill-order FIFO.
//  Output:
//    - Oldest FULL bank goes DRAINING. Registered read: first out_valid is 1 cycle after the bank
//      became FULL (or 1 cycle after the previous bank freed, whichever is later).
//    - While out_valid && !out_ready: out_re, out_im, out_last are held stable.
//    - Each accepted sample advances the read address by 1.
//    - Sample N_POINTS-1 is accepted: bank -> EMPTY the same edge, and it may be refilled
//      from the next cycle.
//    - If the other bank is FULL, its sample 0 is presented on the very next cycle
//      (no bubble, back-to-back frames).
//  Simultaneous events:
//    - A bank freeing on the same edge as an in_start does NOT count as EMPTY for that start;
//      the frame is dropped.
//    - Capture and drain of different banks proceed concurrently.
//  Throughput: sustained LANES samples/cycle in, 1/cycle out.
//    Any LANES > 1 stream overflows unless frame starts are spaced >= N_POINTS cycles apart.
// TESTING
//  1. BITREV=0, LANES=2, N=64. Beats carry re=k, im=-k (k=0..63) over 32 cycles; out_ready=1.
//     -> out_re 0..63 and out_im 0..-63 in order; out_last only at 63; first out_valid 1 cycle after beat 31.
//  2. BITREV=1. Lane data = bitrev6(k) for k=0..63.
//     -> output 0,1,2,...,63; no gaps.
//  3. Backpressure: out_ready toggles 1,0,0,1 repeating.
//     -> every sample seen exactly once, in order; data is held during out_ready=0; no overflow.
//  4. Overflow: out_ready=0; three frames started 32 cycles apart.
//     -> overflow pulse at the 3rd in_start. Then out_ready=1 -> frame 1 then frame 2 intact,
//        128 samples total, out_last twice.
//  5. Restart: in_start reasserted at beat 10 of a frame with new data 100..163.
//     -> output is 100..163 only; no overflow.
//  6. nrst low for 1 cycle mid-drain at sample 20.
//     -> out_valid, busy and overflow are 0 immediately. The next full frame after release
//        drains correctly from sample 0.

Source files
------------

// File: rtl/fft_out_reorder_buf_if.sv
// fft_out_reorder_buf_if: capture-side beat bus and replay-side valid/ready stream of the FFT output buffer.
interface fft_out_reorder_buf_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 2
);
    logic                    in_start;
    logic                    in_valid;
    logic [LANES*DATA_W-1:0] in_re;
    logic [LANES*DATA_W-1:0] in_im;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_re;
    logic [DATA_W-1:0]       out_im;
    logic                    out_last;
    logic                    overflow;
    logic                    busy;
    modport master (
        output in_start, in_valid, in_re, in_im, out_ready,
        input  out_valid, out_re, out_im, out_last, overflow, busy
    );
    modport slave (
        input  in_start, in_valid, in_re, in_im, out_ready,
        output out_valid, out_re, out_im, out_last, overflow, busy
    );
endinterface

// File: rtl/fft_out_reorder_buf.sv
// fft_out_reorder_buf: ping-pong frame buffer that captures LANES samples per beat (optionally
// bit-reversed) and replays them in natural order, one per accepted handshake.
module fft_out_reorder_buf #(
    parameter int N_POINTS = 64,
    parameter int DATA_W   = 16,
    parameter int LANES    = 2,
    parameter bit BITREV   = 1
) (
    input logic clk,
    input logic nrst,
    fft_out_reorder_buf_if.slave bus
);
    localparam int AW = N_POINTS > 1 ? $clog2(N_POINTS) : 1;
    localparam logic [AW-1:0] LAST_BEAT = AW'(N_POINTS / LANES - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(N_POINTS - 1);
    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;
    bank_st_t            st [2];
    logic [2*DATA_W-1:0] mem [2][N_POINTS];
    logic [AW-1:0]       wr_beat, rd_addr, wb, na;
    logic                rd_bank, nb;
    logic [1:0]          fo, cnt;
    logic                start, fill_any, can_start, tgt, we, wlast, push, pop, acc, fin, adv;
    function automatic logic [AW-1:0] waddr(input logic [AW-1:0] b, input int l);
        logic [AW-1:0] k, r;
        k = AW'(int'(b) * LANES + l);
        for (int i = 0; i < AW; i++) r[i] = k[AW-1-i];
        return BITREV ? r : k;
    endfunction
    // A FILLING bank takes priority so a restart never strands a half-written bank.
    always_comb begin
        start     = bus.in_valid && bus.in_start;
        fill_any  = st[0] == FILLING || st[1] == FILLING;
        can_start = fill_any || st[0] == EMPTY || st[1] == EMPTY;
        tgt       = fill_any ? st[1] == FILLING : st[0] != EMPTY;
        we        = bus.in_valid && (start ? can_start : fill_any);
        wb        = start ? '0 : wr_beat;
        wlast     = wb == LAST_BEAT;
        push      = we && wlast;
        acc       = bus.out_valid && bus.out_ready;
        fin       = acc && bus.out_last;
        pop       = cnt != 2'd0 && (!bus.out_valid || fin);
        adv       = pop || (acc && !fin);
        nb        = pop ? fo[0] : rd_bank;
        na        = pop ? '0 : rd_addr + 1'b1;
    end
    always_ff @(posedge clk)
        if (we)
            for (int l = 0; l < LANES; l++)
                mem[tgt][waddr(wb, l)] <= {bus.in_re[l*DATA_W +: DATA_W], bus.in_im[l*DATA_W +: DATA_W]};
    // States are read as registered, so a bank freed this edge is not yet EMPTY for a start.
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            st[0]         <= EMPTY;
            st[1]         <= EMPTY;
            wr_beat       <= '0;
            rd_addr       <= '0;
            rd_bank       <= 1'b0;
            fo            <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_re    <= '0;
            bus.out_im    <= '0;
            bus.out_last  <= 1'b0;
            bus.overflow  <= 1'b0;
        end else begin
            bus.overflow <= start && !can_start;
            if (we) begin
                st[tgt] <= wlast ? FULL : FILLING;
                wr_beat <= wb + 1'b1;
            end
            if (fin) st[rd_bank] <= EMPTY;
            if (pop) begin
                st[fo[0]] <= DRAINING;
                fo[0]     <= fo[1];
            end
            if (push) fo[cnt[0] ^ pop] <= tgt;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            if (adv) begin
                bus.out_valid              <= 1'b1;
                {bus.out_re, bus.out_im}   <= mem[nb][na];
                bus.out_last               <= na == LAST_ADDR;
                rd_bank                    <= nb;
                rd_addr                    <= na;
            end else if (fin) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
        end
    assign bus.busy = st[0] != EMPTY || st[1] != EMPTY;
endmodule
